// File: rtl/ram_readback.sv
// rtl/ram_readback.sv - streams a contiguous RAM address range out on a valid/ready interface
//
// Purpose: on a start pulse, walks base_addr .. base_addr+count-1 (wrapping mod 2**ADDR_BITS),
// issues one-cycle-latency RAM reads and streams the words out through a 2-entry output FIFO.
// The first read is issued in the start cycle itself, so the first word is valid two cycles
// after start. A read is issued only while FIFO occupancy plus in-flight reads (net of a pop in
// the same cycle) is below 2, so RAM data is never dropped and the RAM is never back-pressured.
//
// Optional feature: define RAM_READBACK_CHKSUM_EN to append one beat carrying the XOR of all data
// words; out_last then marks that beat, and count==0 emits a single all-zero beat.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active high
//   start      in   single-cycle dump request, only honoured in IDLE
//   base_addr  in   first address, sampled with start
//   count      in   number of words, sampled with start; clamped to 2**ADDR_BITS
//   busy       out  high from the cycle after an accepted start through the done cycle
//   done       out  one-cycle pulse after the last beat is accepted
//   ram_addr   out  RAM read address
//   ram_rd_en  out  RAM read strobe; ram_data is valid the following cycle
//   ram_data   in   RAM read data
//   out_data   out  streamed word
//   out_valid  out  out_data valid
//   out_ready  in   downstream ready
//   out_last   out  final beat of the dump
module ram_readback #(
  parameter int N         = 64,
  parameter int ADDR_BITS = 4,
  parameter int CNT_BITS  = ADDR_BITS + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [CNT_BITS-1:0]  count,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_rd_en,
  input  logic [N-1:0]         ram_data,
  output logic [N-1:0]         out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam logic [CNT_BITS-1:0] NUM_WORDS = CNT_BITS'(2 ** ADDR_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_BITS-1:0] r_addr;
  logic [CNT_BITS-1:0]  r_issue_left;
  logic                 r_inflight;

  // Output FIFO: two entries, 1-bit pointers, explicit occupancy.
  logic [N-1:0]         r_mem_data [2];
  logic                 r_mem_last [2];
  logic                 r_wptr;
  logic                 r_rptr;
  logic [1:0]           r_occ;

  logic                 w_accept;
  logic [CNT_BITS-1:0]  w_cnt;
  logic                 w_pop;
  logic [2:0]           w_outstanding;
  logic                 w_issue;
  logic [CNT_BITS-1:0]  w_issue_left_next;
  logic                 w_push;
  logic [N-1:0]         w_push_data;
  logic                 w_push_last;

`ifdef RAM_READBACK_CHKSUM_EN
  logic                 r_chk_pending;
  logic [N-1:0]         r_xor;
  logic                 w_chk_push;
`else
  logic                 r_inflight_last;
`endif

  assign w_accept  = (r_state == S_IDLE) && start && !rst;
  assign w_cnt     = (count > NUM_WORDS) ? NUM_WORDS : count;
  assign out_valid = (r_occ != 2'd0);
  assign out_data  = out_valid ? r_mem_data[r_rptr] : '0;
  assign out_last  = out_valid && r_mem_last[r_rptr];
  assign w_pop     = out_valid && out_ready;

  // Words already committed to the FIFO path, after the pop happening this cycle.
  assign w_outstanding = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};

  // The accept cycle issues the first read at base_addr directly from the inputs.
  always_comb begin
    w_issue           = 1'b0;
    w_issue_left_next = r_issue_left;
    if (w_accept) begin
      w_issue           = (w_cnt != '0);
      w_issue_left_next = w_cnt - CNT_BITS'(w_issue);
    end else if ((r_state == S_READ) && (r_issue_left != '0) && (w_outstanding < 3'd2)) begin
      w_issue           = 1'b1;
      w_issue_left_next = r_issue_left - 1'b1;
    end
  end

  assign ram_rd_en = w_issue;
  assign ram_addr  = w_accept ? base_addr : r_addr;

`ifdef RAM_READBACK_CHKSUM_EN
  // Checksum beat goes in once every read has returned and a slot is free.
  assign w_chk_push  = r_chk_pending && (r_state != S_IDLE) && (r_issue_left == '0) &&
                       !r_inflight && ((r_occ != 2'd2) || w_pop);
  assign w_push      = r_inflight || w_chk_push;
  assign w_push_data = r_inflight ? ram_data : r_xor;
  assign w_push_last = w_chk_push;
`else
  assign w_push      = r_inflight;
  assign w_push_data = ram_data;
  assign w_push_last = r_inflight_last;
`endif

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef RAM_READBACK_CHKSUM_EN
          w_next = S_READ;
`else
          w_next = (w_cnt != '0) ? S_READ : S_FINISH;
`endif
        end
      end
      S_READ: begin
        busy = 1'b1;
        if (w_issue_left_next == '0) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_pop && out_last) w_next = S_FINISH;
      end
      S_FINISH: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_issue_left  <= '0;
      r_inflight    <= 1'b0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_occ         <= 2'd0;
      r_mem_data[0] <= '0;
      r_mem_data[1] <= '0;
      r_mem_last[0] <= 1'b0;
      r_mem_last[1] <= 1'b0;
`ifdef RAM_READBACK_CHKSUM_EN
      r_chk_pending <= 1'b0;
      r_xor         <= '0;
`else
      r_inflight_last <= 1'b0;
`endif
    end else begin
      r_state      <= w_next;
      r_issue_left <= w_issue_left_next;
      r_inflight   <= w_issue;
      if (w_issue) r_addr <= ram_addr + 1'b1;
      if (w_push) begin
        r_mem_data[r_wptr] <= w_push_data;
        r_mem_last[r_wptr] <= w_push_last;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
`ifdef RAM_READBACK_CHKSUM_EN
      if (w_accept) begin
        r_chk_pending <= 1'b1;
        r_xor         <= '0;
      end else begin
        if (w_chk_push) r_chk_pending <= 1'b0;
        if (r_inflight) r_xor <= r_xor ^ ram_data;
      end
`else
      r_inflight_last <= w_issue && (w_issue_left_next == '0);
`endif
    end
  end

endmodule
